// File: rtl/disp_mode_ctrl_if.sv
// Control/status bundle between the display-mode scheduler and the VGA datapath.
// The slave side is the scheduler; the master side drives sync and the raw buttons.
interface disp_mode_ctrl_if;
   logic       VGA_VS;
   logic       BTN_NEXT;
   logic       BTN_AUTO;
   logic [3:0] MODE;
   logic       AUTO;
   logic       FRAME_TICK;
   logic       PENDING;

   modport master (
      output VGA_VS, BTN_NEXT, BTN_AUTO,
      input  MODE, AUTO, FRAME_TICK, PENDING
   );

   modport slave (
      input  VGA_VS, BTN_NEXT, BTN_AUTO,
      output MODE, AUTO, FRAME_TICK, PENDING
   );
endinterface

// File: rtl/disp_mode_ctrl.sv
// Display-mode scheduler: debounced NEXT/AUTO buttons and frame-aligned stepping
// of the pattern-select code, either on request (manual) or every HOLD_FRAMES (auto).
module disp_mode_ctrl #(
   parameter int unsigned NMODE       = 4,
   parameter int unsigned HOLD_FRAMES = 120,
   parameter int unsigned DB_CYCLES   = 250000
) (
   input  logic            CLK,
   input  logic            RST,
   disp_mode_ctrl_if.slave bus
);
   localparam int unsigned DB_W    = $clog2(DB_CYCLES);
   localparam int unsigned CNT_W   = $clog2(HOLD_FRAMES + 1);
   localparam int unsigned IX_NEXT = 0;
   localparam int unsigned IX_AUTO = 1;

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_AUTO   = 1'b1
   } state_e;

   // Button path: index IX_NEXT is BTN_NEXT, IX_AUTO is BTN_AUTO
   logic [1:0]      meta_q;
   logic [1:0]      sync_q;
   logic [1:0]      db_lvl_q;
   logic [1:0]      db_lvl_d;
   logic [1:0]      press_p;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];

   state_e          state_q;
   logic [3:0]      mode_q;
   logic [3:0]      mode_inc;
   logic [CNT_W-1:0] frame_cnt_q;
   logic            vs_q;
   logic            tick_q;
   logic            pending_q;
   logic            frame_fall;
   logic            next_p;
   logic            auto_p;

   // NOTE: every always_comb output gets a default before any branch, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         db_cnt_d[b] = '0;
         db_lvl_d[b] = db_lvl_q[b];
         if (sync_q[b] != db_lvl_q[b]) begin
            if (db_cnt_q[b] == DB_W'(DB_CYCLES - 1)) begin
               db_lvl_d[b] = ~db_lvl_q[b];
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
            end
         end
      end
   end

   // The press pulse coincides with the edge that raises the debounced level.
   assign press_p    = db_lvl_d & ~db_lvl_q;
   assign next_p     = press_p[IX_NEXT];
   assign auto_p     = press_p[IX_AUTO];
   assign frame_fall = vs_q & ~bus.VGA_VS;
   assign mode_inc   = (mode_q == 4'(NMODE - 1)) ? 4'd0 : mode_q + 4'd1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         meta_q   <= '0;
         sync_q   <= '0;
         db_lvl_q <= '0;
         for (int b = 0; b < 2; b++) begin
            db_cnt_q[b] <= '0;
         end
      end else begin
         meta_q   <= {bus.BTN_AUTO, bus.BTN_NEXT};
         sync_q   <= meta_q;
         db_lvl_q <= db_lvl_d;
         for (int b = 0; b < 2; b++) begin
            db_cnt_q[b] <= db_cnt_d[b];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_MANUAL;
         mode_q      <= '0;
         frame_cnt_q <= '0;
         vs_q        <= 1'b1;
         tick_q      <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         vs_q   <= bus.VGA_VS;
         tick_q <= frame_fall;

         if (frame_fall) begin
            // A press landing on the tick edge is carried into the next frame.
            pending_q <= next_p;
            if (pending_q) begin
               mode_q      <= mode_inc;
               frame_cnt_q <= '0;
            end else if (state_q == ST_AUTO) begin
               if (frame_cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
                  mode_q      <= mode_inc;
                  frame_cnt_q <= '0;
               end else begin
                  frame_cnt_q <= frame_cnt_q + CNT_W'(1);
               end
            end else begin
               frame_cnt_q <= '0;
            end
         end else if (next_p) begin
            pending_q <= 1'b1;
         end

         if (auto_p) begin
            frame_cnt_q <= '0;
            case (state_q)
               ST_MANUAL: state_q <= ST_AUTO;
               ST_AUTO:   state_q <= ST_MANUAL;
               default:   state_q <= ST_MANUAL;
            endcase
         end
      end
   end

   assign bus.MODE       = mode_q;
   assign bus.AUTO       = (state_q == ST_AUTO);
   assign bus.FRAME_TICK = tick_q;
   assign bus.PENDING    = pending_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Scoreboard bench for disp_mode_ctrl: each VS fall pushes the predicted post-tick
// state, and every FRAME_TICK seen on the bus pops and compares it.
module tb_disp_mode_ctrl;
   localparam int unsigned NMODE = 4;
   localparam int unsigned HOLD  = 3;
   localparam int unsigned DB    = 4;

   typedef struct packed {
      logic [3:0] mode;
      logic       pending;
      logic       auto_s;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   disp_mode_ctrl_if bus ();

   disp_mode_ctrl #(
      .NMODE      (NMODE),
      .HOLD_FRAMES(HOLD),
      .DB_CYCLES  (DB)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int         n_cmp      = 0;
   int         n_err      = 0;
   int         ticks_seen = 0;
   int         m_ticks    = 0;
   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [3:0] m_mode     = 4'd0;
   logic       m_pending  = 1'b0;
   logic       m_auto     = 1'b0;
   int         m_cnt      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mode"},    32'(bus.MODE),       32'd0);
      check({tag, "_auto"},    32'(bus.AUTO),       32'd0);
      check({tag, "_pending"}, 32'(bus.PENDING),    32'd0);
      check({tag, "_tick"},    32'(bus.FRAME_TICK), 32'd0);
   endtask

   // Monitor: every FRAME_TICK must match the oldest prediction.
   always @(negedge clk) begin
      if (bus.FRAME_TICK === 1'b1) begin
         ticks_seen++;
         check("tick_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("tick_mode",    32'(bus.MODE),    32'(mon_e.mode));
            check("tick_pending", 32'(bus.PENDING), 32'(mon_e.pending));
            check("tick_auto",    32'(bus.AUTO),    32'(mon_e.auto_s));
         end
      end
   end

   // Predict the tick outcome, queue it, then pull VS low.
   task automatic vs_fall(input logic coincident);
      exp_t e;
      if (m_pending) begin
         m_mode = 4'((int'(m_mode) + 1) % NMODE);
         m_cnt  = 0;
      end else if (m_auto && m_cnt == int'(HOLD) - 1) begin
         m_mode = 4'((int'(m_mode) + 1) % NMODE);
         m_cnt  = 0;
      end else if (m_auto) begin
         m_cnt++;
      end else begin
         m_cnt = 0;
      end
      m_pending = coincident;
      e.mode    = m_mode;
      e.pending = m_pending;
      e.auto_s  = m_auto;
      sb_q.push_back(e);
      m_ticks++;
      bus.VGA_VS = 1'b0;
   endtask

   task automatic frame();
      step();
      vs_fall(1'b0);
      repeat (3) step();
      bus.VGA_VS = 1'b1;
      repeat (4) step();
      check("tick_count", 32'(ticks_seen), 32'(m_ticks));
   endtask

   // Clean 10-cycle press; the debounced effect must appear exactly 6 cycles in.
   task automatic press(input logic is_auto);
      logic exp_before;
      logic exp_after;
      exp_before = is_auto ? m_auto : m_pending;
      exp_after  = is_auto ? ~m_auto : 1'b1;
      step();
      if (is_auto) bus.BTN_AUTO = 1'b1;
      else         bus.BTN_NEXT = 1'b1;
      repeat (5) step();
      @(negedge clk);
      if (is_auto) check("auto_before", 32'(bus.AUTO),    32'(exp_before));
      else         check("pend_before", 32'(bus.PENDING), 32'(exp_before));
      @(negedge clk);
      if (is_auto) check("auto_after",  32'(bus.AUTO),    32'(exp_after));
      else         check("pend_after",  32'(bus.PENDING), 32'(exp_after));
      if (is_auto) begin
         m_auto = ~m_auto;
         m_cnt  = 0;
      end else begin
         m_pending = 1'b1;
      end
      repeat (4) step();
      bus.BTN_NEXT = 1'b0;
      bus.BTN_AUTO = 1'b0;
      repeat (8) step();
   endtask

   // NEXT press whose pulse lands in the same cycle as the VS fall.
   task automatic press_at_tick();
      step();
      bus.BTN_NEXT = 1'b1;
      repeat (5) step();
      vs_fall(1'b1);
      repeat (3) step();
      bus.VGA_VS = 1'b1;
      repeat (2) step();
      bus.BTN_NEXT = 1'b0;
      repeat (8) step();
      check("tick_count", 32'(ticks_seen), 32'(m_ticks));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.VGA_VS   = 1'b1;
      bus.BTN_NEXT = 1'b0;
      bus.BTN_AUTO = 1'b0;
      rst          = 1'b1;

      // Reset held with buttons toggling
      for (int i = 0; i < 3; i++) begin
         step();
         bus.BTN_NEXT = ~bus.BTN_NEXT;
         bus.BTN_AUTO = i[0];
         @(negedge clk);
         check_all_zero("rst_hold");
      end
      step();
      bus.BTN_NEXT = 1'b0;
      bus.BTN_AUTO = 1'b0;
      rst          = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         check_all_zero("rst_release");
      end

      // 3-cycle glitch is rejected
      step();
      bus.BTN_NEXT = 1'b1;
      repeat (3) step();
      bus.BTN_NEXT = 1'b0;
      repeat (8) step();
      @(negedge clk);
      check("glitch_pending", 32'(bus.PENDING), 32'd0);

      // Clean press then frame boundary
      press(1'b0);
      frame();
      @(negedge clk);
      check("step1_mode",    32'(bus.MODE),    32'd1);
      check("step1_pending", 32'(bus.PENDING), 32'd0);

      // Three presses coalesce into one step
      press(1'b0);
      press(1'b0);
      press(1'b0);
      frame();
      frame();
      @(negedge clk);
      check("coalesce_mode", 32'(bus.MODE), 32'd2);

      // Wrap from NMODE-1 to 0
      press(1'b0);
      frame();
      press(1'b0);
      frame();
      @(negedge clk);
      check("wrap_mode", 32'(bus.MODE), 32'd0);

      // Auto: a step every HOLD frames, then frozen in manual
      press(1'b1);
      repeat (12) frame();
      @(negedge clk);
      check("auto_cycle_mode", 32'(bus.MODE), 32'd0);
      press(1'b1);
      repeat (5) frame();
      @(negedge clk);
      check("manual_frozen_mode", 32'(bus.MODE), 32'd0);
      check("manual_auto",        32'(bus.AUTO), 32'd0);

      // Press coincident with a tick while PENDING
      press(1'b0);
      press_at_tick();
      @(negedge clk);
      check("coinc_mode",    32'(bus.MODE),    32'd1);
      check("coinc_pending", 32'(bus.PENDING), 32'd1);
      frame();
      @(negedge clk);
      check("coinc2_mode",    32'(bus.MODE),    32'd2);
      check("coinc2_pending", 32'(bus.PENDING), 32'd0);

      // Auto with PENDING at counter=HOLD-1: exactly one step
      press(1'b1);
      frame();
      frame();
      press(1'b0);
      frame();
      frame();
      @(negedge clk);
      check("auto_pend_mode", 32'(bus.MODE), 32'd3);
      press(1'b0);
      frame();

      // Reset asserted in the FRAME_TICK cycle with PENDING set
      press(1'b0);
      step();
      bus.BTN_NEXT = 1'b1;
      repeat (5) step();
      vs_fall(1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst          = 1'b1;
      bus.VGA_VS   = 1'b1;
      bus.BTN_NEXT = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("midrst");
      step();
      rst       = 1'b0;
      m_mode    = 4'd0;
      m_pending = 1'b0;
      m_auto    = 1'b0;
      m_cnt     = 0;
      repeat (2) step();
      @(negedge clk);
      check_all_zero("midrst_after");

      check("sb_empty",         32'(sb_q.size()), 32'd0);
      check("final_tick_count", 32'(ticks_seen),  32'(m_ticks));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
